// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   - SZ_* size codes, which are also the register-file write-enable encoding.
//   - lsu_state_e: FSM encoding (S_IDLE, S_ACCESS, S_WB).
//   - is_misaligned(): the alignment rule for a size code and the low address bits.
package lsu_pkg;

    localparam logic [1:0] SZ_NONE = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_WB     = 2'b10
    } lsu_state_e;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        return ((size == SZ_HALF) && addr_lo[0]) || ((size == SZ_WORD) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic for the load/store unit.
// Ports:
//   size_i, addr_lo_i   access size code and ADDR[1:0]
//   store_data_i        right-aligned store data
//   be_o                byte-lane enables
//   wdata_o             store data replicated across lanes
//   shift_o             right-shift amount in bits that brings a loaded field to bit 0
//   misalign_o          access violates natural alignment
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] store_data_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [4:0]  shift_o,
    output logic        misalign_o
);

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = store_data_i;
        unique case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            SZ_HALF: begin
                be_o    = 4'b0011 << addr_lo_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
            default: ;
        endcase
    end

    assign shift_o    = {addr_lo_i, 3'b000};
    assign misalign_o = is_misaligned(size_i, addr_lo_i);

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle load/store engine between execute and the register-file write port.
// Optional feature macro: LSU_TIMEOUT_EN enables the ack watchdog (TIMEOUT_CYCLES).
// Ports:
//   CLK, RESETn                    clock, asynchronous active-low reset
//   LS_VALID/LS_READY              op handshake (ready only in IDLE)
//   IS_LOAD, SIZE, SIGNED, ADDR,
//   STORE_DATA, RD                 op fields, latched on accept
//   MEM_REQ/WE/BE/ADDR/WDATA       data-memory request, held until MEM_ACK
//   MEM_ACK, MEM_RDATA             completion and read data (same cycle)
//   WE3, A3, WD3, sign_for_reg     one-cycle register write for loads
//   MISALIGN, BUS_ERR              one-cycle error pulses
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic        LS_VALID,
    output logic        LS_READY,
    input  logic        IS_LOAD,
    input  logic [1:0]  SIZE,
    input  logic        SIGNED,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    input  logic [4:0]  RD,
    output logic        MEM_REQ,
    output logic        MEM_WE,
    output logic [3:0]  MEM_BE,
    output logic [31:0] MEM_ADDR,
    output logic [31:0] MEM_WDATA,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_RDATA,
    output logic [1:0]  WE3,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        sign_for_reg,
    output logic        MISALIGN,
    output logic        BUS_ERR
);

    lsu_state_e  state_q;
    logic [29:0] addr_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [4:0]  rd_q;
    logic        is_load_q;
    logic [3:0]  be_q;
    logic [31:0] wdata_q;
    logic [4:0]  shift_q;
    logic        mem_req_q;
    logic        misalign_q;
    logic [1:0]  we3_q;
    logic [4:0]  a3_q;
    logic [31:0] wd3_q;
    logic        sign_q;

    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [4:0]  shift_c;
    logic        misalign_c;

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0]  cnt_q;
    logic        bus_err_q;
`endif

    // Lane decode from the incoming op; results are latched on accept so MEM_* stay stable.
    lsu_align u_align (
        .size_i       (SIZE),
        .addr_lo_i    (ADDR[1:0]),
        .store_data_i (STORE_DATA),
        .be_o         (be_c),
        .wdata_o      (wdata_c),
        .shift_o      (shift_c),
        .misalign_o   (misalign_c)
    );

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            size_q     <= SZ_NONE;
            signed_q   <= 1'b0;
            rd_q       <= '0;
            is_load_q  <= 1'b0;
            be_q       <= '0;
            wdata_q    <= '0;
            shift_q    <= '0;
            mem_req_q  <= 1'b0;
            misalign_q <= 1'b0;
            we3_q      <= SZ_NONE;
            a3_q       <= '0;
            wd3_q      <= '0;
            sign_q     <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            cnt_q      <= '0;
            bus_err_q  <= 1'b0;
`endif
        end else begin
            misalign_q <= 1'b0;
`ifdef LSU_TIMEOUT_EN
            bus_err_q  <= 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    if (LS_VALID) begin
                        addr_q    <= ADDR[31:2];
                        size_q    <= SIZE;
                        signed_q  <= SIGNED;
                        rd_q      <= RD;
                        is_load_q <= IS_LOAD;
                        be_q      <= be_c;
                        wdata_q   <= wdata_c;
                        shift_q   <= shift_c;
                        if (SIZE != SZ_NONE) begin
                            if (misalign_c) begin
                                misalign_q <= 1'b1;
                            end else begin
                                state_q   <= S_ACCESS;
                                mem_req_q <= 1'b1;
`ifdef LSU_TIMEOUT_EN
                                cnt_q     <= '0;
`endif
                            end
                        end
                    end
                end
                S_ACCESS: begin
                    if (MEM_ACK) begin
                        mem_req_q <= 1'b0;
                        if (is_load_q) begin
                            wd3_q   <= MEM_RDATA >> shift_q;
                            // x0 is hardwired zero: suppress the write entirely.
                            we3_q   <= (rd_q == 5'd0) ? SZ_NONE : size_q;
                            a3_q    <= rd_q;
                            sign_q  <= signed_q;
                            state_q <= S_WB;
                        end else begin
                            state_q <= S_IDLE;
                        end
`ifdef LSU_TIMEOUT_EN
                    end else if (cnt_q == TimeoutLast) begin
                        mem_req_q <= 1'b0;
                        bus_err_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
`endif
                    end
                end
                S_WB: begin
                    we3_q   <= SZ_NONE;
                    a3_q    <= '0;
                    wd3_q   <= '0;
                    sign_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign LS_READY     = (state_q == S_IDLE);
    assign MEM_REQ      = mem_req_q;
    assign MEM_WE       = mem_req_q & ~is_load_q;
    assign MEM_BE       = mem_req_q ? be_q : 4'b0000;
    assign MEM_ADDR     = mem_req_q ? {addr_q, 2'b00} : 32'd0;
    assign MEM_WDATA    = mem_req_q ? wdata_q : 32'd0;
    assign WE3          = we3_q;
    assign A3           = a3_q;
    assign WD3          = wd3_q;
    assign sign_for_reg = sign_q;
    assign MISALIGN     = misalign_q;
`ifdef LSU_TIMEOUT_EN
    assign BUS_ERR      = bus_err_q;
`else
    assign BUS_ERR      = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a cycle-level expectation model.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        CLK = 1'b0;
    logic        RESETn;
    logic        LS_VALID, LS_READY, IS_LOAD, SIGNED;
    logic [1:0]  SIZE;
    logic [31:0] ADDR, STORE_DATA;
    logic [4:0]  RD;
    logic        MEM_REQ, MEM_WE, MEM_ACK;
    logic [3:0]  MEM_BE;
    logic [31:0] MEM_ADDR, MEM_WDATA, MEM_RDATA;
    logic [1:0]  WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        sign_for_reg, MISALIGN, BUS_ERR;

    load_store_unit #(.TIMEOUT_CYCLES(TMO)) dut (
        .CLK(CLK), .RESETn(RESETn), .LS_VALID(LS_VALID), .LS_READY(LS_READY),
        .IS_LOAD(IS_LOAD), .SIZE(SIZE), .SIGNED(SIGNED), .ADDR(ADDR),
        .STORE_DATA(STORE_DATA), .RD(RD), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE),
        .MEM_BE(MEM_BE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_ACK(MEM_ACK),
        .MEM_RDATA(MEM_RDATA), .WE3(WE3), .A3(A3), .WD3(WD3),
        .sign_for_reg(sign_for_reg), .MISALIGN(MISALIGN), .BUS_ERR(BUS_ERR)
    );

    always #5 CLK = ~CLK;

    int n_vec = 0;
    int n_fail = 0;
    bit check_en = 1'b0;
    int req_cycles = 0;

    // Expected outputs for the current cycle.
    logic        exp_ready, exp_req, exp_we, exp_sign, exp_mis, exp_buserr;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_wd3;
    logic [1:0]  exp_we3;
    logic [4:0]  exp_a3;

    // DUT values snapshotted at interesting cycles for literal checks.
    logic [3:0]  seen_be;
    logic [31:0] seen_wdata, seen_wd3;
    logic        seen_we, seen_sign;
    logic [1:0]  seen_we3;
    logic [4:0]  seen_a3;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (check_en) begin
            chk("LS_READY", 32'(LS_READY), 32'(exp_ready));
            chk("MEM_REQ", 32'(MEM_REQ), 32'(exp_req));
            chk("MEM_WE", 32'(MEM_WE), 32'(exp_we));
            chk("MEM_BE", 32'(MEM_BE), 32'(exp_be));
            chk("MEM_ADDR", MEM_ADDR, exp_addr);
            chk("MEM_WDATA", MEM_WDATA, exp_wdata);
            chk("WE3", 32'(WE3), 32'(exp_we3));
            chk("A3", 32'(A3), 32'(exp_a3));
            chk("WD3", WD3, exp_wd3);
            chk("sign_for_reg", 32'(sign_for_reg), 32'(exp_sign));
            chk("MISALIGN", 32'(MISALIGN), 32'(exp_mis));
            chk("BUS_ERR", 32'(BUS_ERR), 32'(exp_buserr));
            if (MEM_REQ) req_cycles++;
        end
    end

    // ---- reference model: plain arithmetic on the op fields ----
    function automatic int nbytes(input logic [1:0] sz);
        return 1 << (int'(sz) - 1);
    endfunction

    function automatic bit model_mis(input logic [1:0] sz, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(sz)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [31:0] a);
        logic [3:0] be = 4'b0000;
        for (int i = 0; i < nbytes(sz); i++) be = be | 4'(1 << (int'(a[1:0]) + i));
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd1) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 2'd2) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [31:0] a);
        return rdata / (32'd1 << (8 * int'(a[1:0])));
    endfunction

    task automatic set_idle();
        exp_ready = 1'b1; exp_req = 1'b0; exp_we = 1'b0; exp_be = '0; exp_addr = '0;
        exp_wdata = '0; exp_we3 = '0; exp_a3 = '0; exp_wd3 = '0; exp_sign = 1'b0;
        exp_mis = 1'b0; exp_buserr = 1'b0;
    endtask

    task automatic set_access(input bit ld, input logic [1:0] sz, input logic [31:0] a,
                              input logic [31:0] sd);
        set_idle();
        exp_ready = 1'b0; exp_req = 1'b1; exp_we = !ld; exp_be = model_be(sz, a);
        exp_addr = a - (a % 4); exp_wdata = model_wdata(sz, sd);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // One complete op; delay < 0 means the ack never arrives.
    task automatic op(input bit ld, input logic [1:0] sz, input bit sg, input logic [31:0] a,
                      input logic [31:0] sd, input logic [4:0] rd, input logic [31:0] rdata,
                      input int delay);
        step();
        LS_VALID = 1'b1; IS_LOAD = ld; SIZE = sz; SIGNED = sg; ADDR = a;
        STORE_DATA = sd; RD = rd;
        set_idle();
        step();
        LS_VALID = 1'b0;
        set_idle();
        if (sz == 2'd0) return;
        if (model_mis(sz, a)) begin
            exp_mis = 1'b1;
            step();
            set_idle();
            return;
        end
        for (int d = 0; (delay < 0) ? (d < TMO) : (d <= delay); d++) begin
            set_access(ld, sz, a, sd);
            MEM_ACK = (d == delay);
            MEM_RDATA = rdata;
            if (d == 0) begin
                @(negedge CLK);
                seen_be = MEM_BE; seen_wdata = MEM_WDATA; seen_we = MEM_WE;
            end
            step();
        end
        MEM_ACK = 1'b0;
        MEM_RDATA = 32'hFFFF_FFFF;
        set_idle();
        if (delay < 0) begin
            exp_buserr = 1'b1;
            step();
            set_idle();
            return;
        end
        if (ld) begin
            exp_ready = 1'b0;
            exp_we3 = (rd == 5'd0) ? 2'd0 : sz;
            exp_a3 = rd; exp_wd3 = model_load(rdata, a); exp_sign = sg;
            @(negedge CLK);
            seen_we3 = WE3; seen_a3 = A3; seen_wd3 = WD3; seen_sign = sign_for_reg;
            step();
            set_idle();
        end
    endtask

    initial begin
        RESETn = 1'b0; LS_VALID = 1'b0; IS_LOAD = 1'b0; SIZE = '0; SIGNED = 1'b0;
        ADDR = '0; STORE_DATA = '0; RD = '0; MEM_ACK = 1'b0; MEM_RDATA = '0;
        set_idle();
        check_en = 1'b1;
        step(); step();
        RESETn = 1'b1;

        // lb signed, top byte lane, immediate ack
        op(1'b1, 2'd1, 1'b1, 32'h103, 32'h0, 5'd5, 32'h80FF_1234, 0);
        chk("t1 WE3 literal", 32'(seen_we3), 32'h1);
        chk("t1 A3 literal", 32'(seen_a3), 32'd5);
        chk("t1 WD3 literal", 32'(seen_wd3[7:0]), 32'h80);
        chk("t1 sign literal", 32'(seen_sign), 32'h1);

        // sh to upper half
        op(1'b0, 2'd2, 1'b0, 32'h202, 32'h0000_ABCD, 5'd0, 32'h0, 0);
        chk("t2 BE literal", 32'(seen_be), 32'hC);
        chk("t2 WDATA literal", seen_wdata, 32'hABCD_ABCD);
        chk("t2 WE literal", 32'(seen_we), 32'h1);

        // misaligned accesses
        op(1'b1, 2'd3, 1'b0, 32'h101, 32'h0, 5'd3, 32'h0, 0);
        op(1'b0, 2'd2, 1'b0, 32'h203, 32'h1234, 5'd0, 32'h0, 0);
        op(1'b1, 2'd3, 1'b0, 32'h102, 32'h0, 5'd4, 32'h0, 0);

        // lw to x0, ack in the fifth access cycle
        req_cycles = 0;
        op(1'b1, 2'd3, 1'b0, 32'h400, 32'h0, 5'd0, 32'hDEAD_BEEF, 4);
        chk("t4 req cycles", 32'(req_cycles), 32'd5);

        // assorted aligned traffic
        op(1'b1, 2'd2, 1'b0, 32'h502, 32'h0, 5'd9, 32'hCAFE_1234, 2);
        op(1'b0, 2'd1, 1'b0, 32'h601, 32'h1122_335A, 5'd0, 32'h0, 1);
        op(1'b0, 2'd3, 1'b0, 32'h700, 32'h89AB_CDEF, 5'd0, 32'h0, 0);
        op(1'b0, 2'd0, 1'b0, 32'h800, 32'h1, 5'd1, 32'h0, 0);
        op(1'b1, 2'd1, 1'b0, 32'h000, 32'h0, 5'd31, 32'h1234_5678, 3);
        op(1'b1, 2'd3, 1'b1, 32'h904, 32'h0, 5'd12, 32'h8765_4321, 0);

        // reset in the middle of an access
        step();
        LS_VALID = 1'b1; IS_LOAD = 1'b1; SIZE = 2'd3; SIGNED = 1'b0; ADDR = 32'h300;
        STORE_DATA = 32'h0; RD = 5'd7;
        set_idle();
        step();
        LS_VALID = 1'b0;
        set_access(1'b1, 2'd3, 32'h300, 32'h0);
        @(negedge CLK);
        #2;
        check_en = 1'b0;
        RESETn = 1'b0;
        #1;
        chk("t5 req drop", 32'(MEM_REQ), 32'h0);
        chk("t5 ready in reset", 32'(LS_READY), 32'h1);
        step(); step();
        RESETn = 1'b1;
        MEM_ACK = 1'b1;
        MEM_RDATA = 32'h5555_AAAA;
        set_idle();
        check_en = 1'b1;
        step(); step(); step();
        MEM_ACK = 1'b0;
        step();

`ifdef LSU_TIMEOUT_EN
        op(1'b1, 2'd3, 1'b0, 32'hA00, 32'h0, 5'd3, 32'h0, -1);
        op(1'b1, 2'd1, 1'b1, 32'hA01, 32'h0, 5'd6, 32'h0000_F000, 0);
`endif

        step(); step();
        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
